uart_dbus_bridge: RTL and testbench
===================================

// Module: uart_dbus_bridge
// PURPOSE
//  UART-driven debug initiator on the dBus-style simple bus (the CPU data-bus protocol). It parses host
//  command bytes from uart_lite RX, issues single 32-bit read/write commands to the memory/IO fabric and
//  returns results over uart_lite TX. Used for loading the RAM and poking IO regs with the CPU held in reset.
// PARAMETERS
//  CLK_FREQ            100000000  clock frequency, Hz
//  RX_TIMEOUT_CYCLES   1000000    max idle cycles between bytes of one command before abort
//  RSP_TIMEOUT_CYCLES  16         max cycles waiting for read rsp_ready before error reply
// PORTS
//  clk            in   1   system clock
//  reset          in   1   async, active-high
//  rx_valid       in   1   1-cycle strobe: rx_data holds a received byte
//  rx_data        in   8   received byte
//  tx_rdy         in   1   uart_lite can accept a byte
//  tx_vld         out  1   byte transfer strobe; accepted when tx_vld && tx_rdy
//  tx_data        out  8   byte to send
//  cmd_valid      out  1   bus command valid
//  cmd_ready      in   1   bus command accepted
//  cmd_wr         out  1   1=write, 0=read
//  cmd_address    out  32  byte address
//  cmd_data       out  32  write data
//  cmd_size       out  2   always 2'b10 (word)
//  rsp_ready      in   1   read data valid
//  rsp_error      in   1   read error, qualified by rsp_ready
//  rsp_data       in   32  read data
//  busy           out  1   high from first opcode byte until reply fully accepted
// BEHAVIOUR
//  Reset: all outputs 0 (cmd_size=2'b10), state IDLE, counters/shift regs cleared. Reset is honoured mid-command.
//  Protocol (multi-byte fields MSB first):
//   'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0 -> bus write; reply 'K'(0x4B)
//   'R'(0x52) A3 A2 A1 A0             -> bus read; reply D3 D2 D1 D0, or 'E'(0x45) on error or timeout
//   Any other byte in IDLE is silently dropped; busy stays 0.
//  FSM: IDLE -> ADDR(4 bytes) -> [W: DATA(4 bytes)] -> BUS_REQ -> [R: BUS_WAIT] -> TX_RESP -> IDLE.
//  Byte counter is 2 bits. It clears on entry to ADDR, DATA and TX_RESP, and wraps 3->0 when each field
//  completes. Bytes shift into 32-bit address/data registers: reg <= {reg[23:0], rx_data}.
//  RX timeout counter clears on every rx_valid. Counting starts on entry to ADDR and stops after the last
//  command byte. When it reaches RX_TIMEOUT_CYCLES-1 in ADDR/DATA: go to IDLE, no bus access, no reply.
//  rx_valid outside IDLE/ADDR/DATA (BUS_*, TX_RESP) is dropped. It is not queued.
//  BUS_REQ: cmd_valid=1 with stable wr/address/data/size until cmd_valid && cmd_ready. cmd_valid drops
//   the following cycle. Write: go to TX_RESP with reply 'K'. Read: go to BUS_WAIT.
//  BUS_WAIT: capture rsp_data when rsp_ready=1. rsp_error=1 -> reply 'E', else 4 data bytes.
//   If rsp_ready is not seen within RSP_TIMEOUT_CYCLES of cmd accept -> reply 'E'.
//   A rsp_ready arriving in the same cycle as the timeout wins (data is returned).
//   rsp_ready outside BUS_WAIT is ignored.
//  TX_RESP: tx_vld=1 and tx_data=current byte only while tx_rdy=1. Each accept advances the byte index.
//   tx_vld is forced 0 for 1 cycle after each accept, so there are no back-to-back strobes.
//   After the last byte: busy=0, go to IDLE. The next command byte is accepted the same cycle busy drops.
//  Latency (fabric rsp 1 cycle after accept, tx_rdy=1): the first reply byte is strobed 2 cycles after cmd
//   accept for writes, and 3 cycles after for reads.
//  Address is passed through unmodified; alignment is the host's responsibility.
// TESTING
//  1. Send 57 00 00 00 10 DE AD BE EF, cmd_ready=1 -> exactly one cmd: wr=1, addr=0x10, data=0xDEADBEEF,
//     size=2; TX byte 0x4B.
//  2. Send 52 00 00 00 10; responder returns 0xDEADBEEF 1 cycle after accept -> TX bytes DE AD BE EF in order.
//  3. Read with rsp_error=1 -> TX single 0x45. Read with no rsp_ready for 16 cycles -> TX 0x45, FSM in IDLE.
//  4. cmd_ready held 0 for 5 cycles -> cmd_valid and all payload stable for 6 cycles; one access only.
//  5. Send 52 00 then idle RX_TIMEOUT_CYCLES -> no cmd_valid, no TX. A following full read then succeeds.
//  6. Async reset asserted during TX_RESP -> tx_vld, cmd_valid and busy go 0 immediately. Byte 0x41 in
//     IDLE -> ignored.

Source files
------------

// File: rtl/uart_dbus_bridge.sv
// UART-driven debug initiator: parses 'W'/'R' host commands from a byte stream,
// issues single word accesses on the simple data bus and returns the reply bytes.
module uart_dbus_bridge #(
  parameter int unsigned CLK_FREQ           = 100000000,
  parameter int unsigned RX_TIMEOUT_CYCLES  = 1000000,
  parameter int unsigned RSP_TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_rdy,
  output logic        tx_vld,
  output logic [7:0]  tx_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_wr,
  output logic [31:0] cmd_address,
  output logic [31:0] cmd_data,
  output logic [1:0]  cmd_size,
  input  logic        rsp_ready,
  input  logic        rsp_error,
  input  logic [31:0] rsp_data,
  output logic        busy
);

  localparam int RXW = $clog2(RX_TIMEOUT_CYCLES + 1);
  localparam int RSW = $clog2(RSP_TIMEOUT_CYCLES + 1);
  localparam logic [RXW-1:0] RX_LAST  = RXW'(RX_TIMEOUT_CYCLES - 1);
  localparam logic [RSW-1:0] RSP_LAST = RSW'(RSP_TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  generate
    if (CLK_FREQ == 0 || RX_TIMEOUT_CYCLES < 1 || RSP_TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("uart_dbus_bridge: parameters must be non-zero");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS_REQ,
    S_BUS_WAIT,
    S_TX_RESP
  } state_t;

  state_t state_reg, state_next;

  logic           is_wr_reg;
  logic [31:0]    addr_reg;
  logic [31:0]    data_reg;
  logic [1:0]     byte_cnt_reg;
  logic [RXW-1:0] rx_timer_reg;
  logic [RSW-1:0] rsp_timer_reg;
  logic [31:0]    tx_shift_reg;
  logic [1:0]     tx_last_reg;
  logic           tx_hold_reg;

  logic rx_expired;
  logic field_done;
  logic rsp_expired;

  assign rx_expired  = !rx_valid && (rx_timer_reg == RX_LAST);
  assign field_done  = rx_valid && (byte_cnt_reg == 2'd3);
  assign rsp_expired = (rsp_timer_reg == RSP_LAST);

  assign cmd_wr      = is_wr_reg;
  assign cmd_address = addr_reg;
  assign cmd_data    = data_reg;
  assign cmd_size    = 2'b10;
  assign busy        = (state_reg != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_valid  = 1'b0;
    tx_vld     = 1'b0;
    tx_data    = 8'h00;
    case (state_reg)
      S_IDLE: begin
        if (rx_valid && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
          state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_expired) begin
          state_next = S_IDLE;
        end else if (field_done) begin
          state_next = is_wr_reg ? S_DATA : S_BUS_REQ;
        end
      end
      S_DATA: begin
        if (rx_expired) begin
          state_next = S_IDLE;
        end else if (field_done) begin
          state_next = S_BUS_REQ;
        end
      end
      S_BUS_REQ: begin
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          state_next = is_wr_reg ? S_TX_RESP : S_BUS_WAIT;
        end
      end
      S_BUS_WAIT: begin
        // A response landing on the timeout cycle still returns data.
        if (rsp_ready || rsp_expired) begin
          state_next = S_TX_RESP;
        end
      end
      S_TX_RESP: begin
        if (tx_rdy) begin
          tx_data = tx_shift_reg[31:24];
          tx_vld  = !tx_hold_reg;
          if (!tx_hold_reg && byte_cnt_reg == tx_last_reg) begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_wr_reg     <= 1'b0;
      addr_reg      <= 32'h0;
      data_reg      <= 32'h0;
      byte_cnt_reg  <= 2'd0;
      rx_timer_reg  <= '0;
      rsp_timer_reg <= '0;
      tx_shift_reg  <= 32'h0;
      tx_last_reg   <= 2'd0;
      tx_hold_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (state_next == S_ADDR) begin
            is_wr_reg    <= (rx_data == OP_WRITE);
            byte_cnt_reg <= 2'd0;
            rx_timer_reg <= '0;
          end
        end
        S_ADDR, S_DATA: begin
          if (rx_valid) begin
            if (state_reg == S_ADDR) begin
              addr_reg <= {addr_reg[23:0], rx_data};
            end else begin
              data_reg <= {data_reg[23:0], rx_data};
            end
            // 2-bit counter wraps to 0 as each 4-byte field completes.
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            rx_timer_reg <= '0;
          end else begin
            rx_timer_reg <= rx_timer_reg + RXW'(1);
          end
        end
        S_BUS_REQ: begin
          if (cmd_ready) begin
            rsp_timer_reg <= '0;
            if (is_wr_reg) begin
              tx_shift_reg <= {RSP_OK, 24'h0};
              tx_last_reg  <= 2'd0;
              byte_cnt_reg <= 2'd0;
              tx_hold_reg  <= 1'b1;
            end
          end
        end
        S_BUS_WAIT: begin
          rsp_timer_reg <= rsp_timer_reg + RSW'(1);
          if (state_next == S_TX_RESP) begin
            if (rsp_ready && !rsp_error) begin
              tx_shift_reg <= rsp_data;
              tx_last_reg  <= 2'd3;
            end else begin
              tx_shift_reg <= {RSP_ERR, 24'h0};
              tx_last_reg  <= 2'd0;
            end
            byte_cnt_reg <= 2'd0;
            tx_hold_reg  <= 1'b1;
          end
        end
        S_TX_RESP: begin
          // Hold is set for one cycle after every accept and on entry.
          if (tx_vld) begin
            tx_shift_reg <= {tx_shift_reg[23:0], 8'h00};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            tx_hold_reg  <= 1'b1;
          end else begin
            tx_hold_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbus_bridge.sv
// Randomised bench for uart_dbus_bridge: a host driver, a bus responder with its
// own memory, and a reference memory that predicts every reply byte.
module tb_uart_dbus_bridge;

  localparam int RX_TO  = 200;
  localparam int RSP_TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_rdy = 1'b0;
  logic        tx_vld;
  logic [7:0]  tx_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_wr;
  logic [31:0] cmd_address;
  logic [31:0] cmd_data;
  logic [1:0]  cmd_size;
  logic        rsp_ready = 1'b0;
  logic        rsp_error = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic        busy;

  uart_dbus_bridge #(
    .CLK_FREQ          (100000000),
    .RX_TIMEOUT_CYCLES (RX_TO),
    .RSP_TIMEOUT_CYCLES(RSP_TO)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_rdy     (tx_rdy),
    .tx_vld     (tx_vld),
    .tx_data    (tx_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_address(cmd_address),
    .cmd_data   (cmd_data),
    .cmd_size   (cmd_size),
    .rsp_ready  (rsp_ready),
    .rsp_error  (rsp_error),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } cmd_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int txn_no = 0;

  int cfg_stall = 0;
  int cfg_delay = 1;
  bit cfg_err = 0;
  bit cfg_rnd_rdy = 0;
  bit tx_rdy_force = 1;

  bit          acc_flag = 0;
  bit          acc_wr = 0;
  logic [31:0] acc_addr = 32'h0;
  int          acc_cyc = 0;
  int          first_tx_cyc = 0;
  bit          first_pending = 0;
  int          rsp_cnt = 0;
  int          stall_left = 0;
  int          valid_cnt = 0;
  bit          stall_chk = 0;
  logic        hold_wr;
  logic [31:0] hold_addr, hold_data;
  bit          prev_tx_acc = 0;

  cmd_t        cmd_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] fab_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  always @(posedge clk) cyc++;

  // Fabric side: cmd_ready after a configurable stall, read response cfg_delay cycles after accept.
  always @(posedge clk) begin
    #1;
    if (!cmd_valid) begin
      cmd_ready  = 1'b0;
      stall_left = cfg_stall;
    end else if (stall_left > 0) begin
      cmd_ready = 1'b0;
      stall_left--;
    end else begin
      cmd_ready = 1'b1;
    end
    rsp_ready = 1'b0;
    rsp_error = 1'b0;
    rsp_data  = 32'h0;
    if (acc_flag) begin
      if (!acc_wr) rsp_cnt = cfg_delay;
      acc_flag = 0;
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        rsp_ready = 1'b1;
        rsp_error = cfg_err;
        rsp_data  = cfg_err ? 32'hBAD0BAD0 :
                    (fab_mem.exists(acc_addr) ? fab_mem[acc_addr] : 32'h0);
      end
    end
    tx_rdy = cfg_rnd_rdy ? 1'($urandom_range(0, 1)) : tx_rdy_force;
  end

  // Observer on the falling edge: logs bus commands and TX bytes, checks handshake rules.
  always @(negedge clk) begin
    if (rst) begin
      stall_chk   = 0;
      prev_tx_acc = 0;
    end else begin
      if (stall_chk) begin
        check("cmd_valid_held", 32'(cmd_valid), 1);
        check("cmd_wr_stable", 32'(cmd_wr), 32'(hold_wr));
        check("cmd_addr_stable", cmd_address, hold_addr);
        check("cmd_data_stable", cmd_data, hold_data);
      end
      stall_chk = 0;
      if (cmd_valid) begin
        valid_cnt++;
        if (cmd_ready) begin
          acc_flag = 1;
          acc_wr   = cmd_wr;
          acc_addr = cmd_address;
          acc_cyc  = cyc;
          cmd_q.push_back('{cmd_wr, cmd_address, cmd_data, cmd_size});
          if (cmd_wr) fab_mem[cmd_address] = cmd_data;
        end else begin
          stall_chk = 1;
          hold_wr   = cmd_wr;
          hold_addr = cmd_address;
          hold_data = cmd_data;
        end
      end
      if (prev_tx_acc) check("tx_gap_after_accept", 32'(tx_vld), 0);
      if (!tx_rdy) check("tx_vld_without_rdy", 32'(tx_vld), 0);
      if (tx_vld && tx_rdy) begin
        tx_q.push_back(tx_data);
        if (first_pending) begin
          first_tx_cyc  = cyc;
          first_pending = 0;
        end
      end
      prev_tx_acc = tx_vld && tx_rdy;
    end
  end

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int stall, input int delay, input bit err,
                         input bit rnd_rdy, input bit stray);
    logic [7:0]  exp_q[$];
    logic [7:0]  bytes[$];
    logic [31:0] rd;
    int          n0;
    int          waited;
    int          n;
    cmd_t        c;
    cfg_stall   = stall;
    cfg_delay   = delay;
    cfg_err     = err;
    cfg_rnd_rdy = rnd_rdy;
    if (wr) begin
      exp_q.push_back(8'h4B);
      ref_mem[addr] = data;
    end else if (err || delay > RSP_TO) begin
      exp_q.push_back(8'h45);
    end else begin
      rd = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
      for (int i = 3; i >= 0; i--) exp_q.push_back(rd[i*8 +: 8]);
    end
    bytes.push_back(wr ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) bytes.push_back(addr[i*8 +: 8]);
    if (wr) for (int i = 3; i >= 0; i--) bytes.push_back(data[i*8 +: 8]);
    n0            = cmd_q.size();
    tx_q.delete();
    first_pending = 1;
    first_tx_cyc  = -1000;
    valid_cnt     = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i]);
      if (i < bytes.size() - 1) repeat ($urandom_range(0, 2)) step();
    end
    if (stray) begin
      repeat (3) step();
      send_byte(8'h57);
    end
    waited = 0;
    while (busy && waited < 400) begin
      step();
      waited++;
    end
    repeat (3) step();
    check("idle_after_reply", 32'(busy), 0);
    check("reply_len", 32'(tx_q.size()), 32'(exp_q.size()));
    n = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("reply_byte%0d", i), 32'(tx_q[i]), 32'(exp_q[i]));
    check("cmd_count", 32'(cmd_q.size() - n0), 1);
    if (cmd_q.size() > n0) begin
      c = cmd_q[n0];
      check("cmd_wr", 32'(c.wr), 32'(wr));
      check("cmd_addr", c.addr, addr);
      check("cmd_size", 32'(c.size), 2);
      if (wr) check("cmd_data", c.data, data);
    end
    check("cmd_valid_cycles", 32'(valid_cnt), 32'(stall + 1));
    if (!rnd_rdy && (wr || delay == 1)) check("first_byte_latency", 32'(first_tx_cyc - acc_cyc), wr ? 2 : 3);
    txn_no++;
    $display("txn %0d: %s addr=%h data=%h stall=%0d dly=%0d err=%0d stray=%0d reply_bytes=%0d",
             txn_no, wr ? "W" : "R", addr, data, stall, delay, err, stray, tx_q.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0;
    logic [7:0]  jb;
    logic [31:0] a;
    bit          wr;

    repeat (3) step();
    check("rst_tx_vld", 32'(tx_vld), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd_wr", 32'(cmd_wr), 0);
    check("rst_cmd_addr", cmd_address, 0);
    check("rst_cmd_data", cmd_data, 0);
    check("rst_cmd_size", 32'(cmd_size), 2);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    step();

    run_txn(1, 32'h10, 32'hDEADBEEF, 0, 1, 0, 0, 0);
    run_txn(0, 32'h10, 32'h0, 0, 1, 0, 0, 0);
    run_txn(0, 32'h10, 32'h0, 0, 1, 1, 0, 0);
    run_txn(0, 32'h10, 32'h0, 0, RSP_TO + 1, 0, 0, 0);
    run_txn(0, 32'h10, 32'h0, 0, RSP_TO, 0, 0, 0);
    run_txn(1, 32'h24, 32'h12345678, 5, 1, 0, 0, 0);
    run_txn(0, 32'h24, 32'h0, 2, 10, 0, 0, 1);

    // Partial command followed by silence must abort without touching the bus.
    n0 = cmd_q.size();
    tx_q.delete();
    send_byte(8'h52);
    send_byte(8'h00);
    repeat (RX_TO - 1) step();
    check("rx_to_still_busy", 32'(busy), 1);
    step();
    check("rx_to_aborted", 32'(busy), 0);
    repeat (5) step();
    check("rx_to_no_cmd", 32'(cmd_q.size() - n0), 0);
    check("rx_to_no_tx", 32'(tx_q.size()), 0);
    run_txn(0, 32'h24, 32'h0, 0, 1, 0, 0, 0);

    // Reset asserted while a reply is being offered.
    cfg_stall    = 0;
    cfg_delay    = 1;
    cfg_err      = 0;
    cfg_rnd_rdy  = 0;
    tx_rdy_force = 0;
    step();
    tx_q.delete();
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(8'(32'h10 >> (i * 8)));
    repeat (10) step();
    check("pre_reset_busy", 32'(busy), 1);
    @(posedge clk);
    #2;
    tx_rdy_force = 1;
    @(posedge clk);
    #2;
    check("pre_reset_tx_vld", 32'(tx_vld), 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_tx_vld", 32'(tx_vld), 0);
    check("async_rst_cmd_valid", 32'(cmd_valid), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_addr", cmd_address, 0);
    #2;
    rst = 1'b0;
    step();
    check("async_rst_no_tx", 32'(tx_q.size()), 0);

    n0 = cmd_q.size();
    send_byte(8'h41);
    repeat (3) step();
    check("junk_41_busy", 32'(busy), 0);
    check("junk_41_no_tx", 32'(tx_q.size()), 0);
    check("junk_41_no_cmd", 32'(cmd_q.size() - n0), 0);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        jb = 8'($urandom);
        if (jb == 8'h57 || jb == 8'h52) jb = 8'h00;
        send_byte(jb);
        step();
        check("junk_busy", 32'(busy), 0);
      end
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 1)) * 32'h8000_0000 + 32'($urandom_range(0, 7)) * 4;
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      run_txn(wr, a, $urandom, $urandom_range(0, 3), $urandom_range(1, 20),
              ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
